adder_bist: RTL and testbench

//  On-chip built-in self-test driver/checker for the 1-bit full adder (test_adder).

---
 rtl/adder_bist_pkg.sv | 19 +
 rtl/adder_bist_settle_timer.sv | 29 ++
 rtl/adder_bist.sv | 99 +++++++++
 tb/tb_adder_bist.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared state encoding, vector count and golden adder function for the adder BIST
package adder_bist_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int NUM_VECTORS = 8;

   // Golden response of a 1-bit full adder for vector {cin,b,a}, returned as {cout,sum}
   function automatic logic [1:0] exp_add(logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/adder_bist_settle_timer.sv
// bist_settle_timer: loadable down-counter that flags the last cycle of the settle window
module bist_settle_timer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic nrst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES);

   logic [W-1:0] cnt;

   // Reload on DRIVE, count down while settling, park at zero otherwise
   always_ff @(posedge clk) begin
      if (!nrst)
         cnt <= '0;
      else if (load)
         cnt <= LOAD_VAL;
      else if (en && cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign expired = en && (cnt == W'(1));

endmodule

// File: rtl/adder_bist.sv
// adder_bist: exhaustive self-test driver/checker for a 1-bit full adder
module adder_bist
   import adder_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             cin_o,
   input  logic             sum_i,
   input  logic             cout_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0]       first_fail,
   output logic [2:0]       vec_idx
);

   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [2:0]       LAST_VEC = 3'(NUM_VECTORS - 1);

   state_t state, state_next;
   logic   settle_done;
   logic   launch;
   logic   last_vec;
   logic   mismatch;

   bist_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .nrst   (nrst),
      .load   (state == DRIVE),
      .en     (state == SETTLE),
      .expired(settle_done)
   );

   assign launch   = (state == IDLE || state == DONE) && start;
   assign last_vec = vec_idx == LAST_VEC;
   assign mismatch = {cout_i, sum_i} != exp_add(vec_idx);
   assign busy     = state == DRIVE || state == SETTLE || state == CHECK;
   assign done     = state == DONE;
   assign pass     = done && err_count == '0;

   // Next-state: start is only honoured when idle or finished, so a running sweep cannot be restarted
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: state_next = start ? DRIVE : state;
         DRIVE:      state_next = SETTLE;
         SETTLE:     state_next = settle_done ? CHECK : SETTLE;
         CHECK:      state_next = last_vec ? DONE : DRIVE;
         default:    state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Operands change only on the DRIVE edge and stay put through SETTLE and CHECK
   always_ff @(posedge clk) begin
      if (!nrst)
         {cin_o, b_o, a_o} <= '0;
      else if (state == DRIVE)
         {cin_o, b_o, a_o} <= vec_idx;
   end

   // Vector counter stops at the last vector so the final index stays visible in DONE
   always_ff @(posedge clk) begin
      if (!nrst || launch)
         vec_idx <= '0;
      else if (state == CHECK && !last_vec)
         vec_idx <= vec_idx + 3'd1;
   end

   // Error bookkeeping: one count per failing vector, saturating, and the first failing index
   always_ff @(posedge clk) begin
      if (!nrst || launch) begin
         err_count  <= '0;
         first_fail <= '0;
      end else if (state == CHECK && mismatch) begin
         if (err_count == '0)
            first_fail <= vec_idx;
         if (err_count != ERR_MAX)
            err_count <= err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: randomized self-checking bench for adder_bist with a faultable adder model
module tb_adder_bist;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [2:0] start = '0;
   logic [2:0] a, b, cin, sum, cout, busy, done, pass;
   logic [3:0] err0, err2;
   logic [1:0] err1;
   logic [2:0] ff [3];
   logic [2:0] vec [3];
   logic [1:0] mode [3] = '{2'd0, 2'd0, 2'd0};
   logic [1:0] flip [8] = '{default: 2'd0};
   int         checks = 0;
   int         errors = 0;
   int         cur = 0;

   logic       c_busy, c_done, c_pass;
   logic [2:0] c_op, c_ff, c_vec;
   logic [3:0] c_err;

   always #5 clk = ~clk;

   // Adder under test: 0 good, 1 cout stuck-at-0, 2 sum inverted, 3 random per-vector corruption
   function automatic logic [1:0] model_add(input logic [1:0] m, input logic [1:0] fl, input logic [2:0] v);
      logic [1:0] r;
      r = 2'($countones(v));
      case (m)
         2'd1:    r[1] = 1'b0;
         2'd2:    r[0] = ~r[0];
         2'd3:    r = r ^ fl;
         default: ;
      endcase
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_add
      assign {cout[g], sum[g]} = model_add(mode[g], flip[{cin[g], b[g], a[g]}], {cin[g], b[g], a[g]});
   end

   adder_bist dut0 (
      .clk(clk), .nrst(nrst), .start(start[0]), .a_o(a[0]), .b_o(b[0]), .cin_o(cin[0]),
      .sum_i(sum[0]), .cout_i(cout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_count(err0), .first_fail(ff[0]), .vec_idx(vec[0])
   );

   adder_bist #(.ERR_W(2)) dut1 (
      .clk(clk), .nrst(nrst), .start(start[1]), .a_o(a[1]), .b_o(b[1]), .cin_o(cin[1]),
      .sum_i(sum[1]), .cout_i(cout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_count(err1), .first_fail(ff[1]), .vec_idx(vec[1])
   );

   adder_bist #(.SETTLE_CYCLES(3)) dut2 (
      .clk(clk), .nrst(nrst), .start(start[2]), .a_o(a[2]), .b_o(b[2]), .cin_o(cin[2]),
      .sum_i(sum[2]), .cout_i(cout[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .err_count(err2), .first_fail(ff[2]), .vec_idx(vec[2])
   );

   always_comb begin
      c_busy = busy[cur];
      c_done = done[cur];
      c_pass = pass[cur];
      c_op   = {cin[cur], b[cur], a[cur]};
      c_ff   = ff[cur];
      c_vec  = vec[cur];
      c_err  = cur == 1 ? {2'b00, err1} : cur == 2 ? err2 : err0;
   end

   // Expected results: walk all 8 vectors, compare the faulty adder with plain a+b+cin
   function automatic void ref_run(input logic [1:0] m, input int w, output int e, output int f);
      logic [2:0] vv;
      e = 0;
      f = 0;
      for (int v = 0; v < 8; v++) begin
         vv = 3'(v);
         if (model_add(m, flip[vv], vv) != 2'($countones(vv))) begin
            if (e == 0) f = v;
            if (e < (1 << w) - 1) e++;
         end
      end
   endfunction

   task automatic run(input int d, input int pulse_at, input bit hold);
      int         s, edges, base, e, f;
      bit         ok;
      logic [2:0] vals[$];
      int         cnts[$];
      s   = (d == 2) ? 3 : 1;
      cur = d;
      @(negedge clk);
      start[d] = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      if (!hold) start[d] = 1'b0;
      checks++;
      if (c_done !== 1'b0 || c_busy !== 1'b1 || c_err !== 4'd0 || c_ff !== 3'd0 || c_vec !== 3'd0) begin
         errors++;
         $display("FAIL run_start_clear dut%0d: done=%b busy=%b err=%0d ff=%0d vec=%0d, want 0 1 0 0 0",
                  d, c_done, c_busy, c_err, c_ff, c_vec);
      end
      while (c_done !== 1'b1 && edges < 200) begin
         if (c_busy === 1'b1) begin
            if (vals.size() == 0 || vals[vals.size()-1] !== c_op) begin
               vals.push_back(c_op);
               cnts.push_back(1);
            end else
               cnts[cnts.size()-1] += 1;
         end
         if (!hold) start[d] = (edges == pulse_at);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      checks++;
      if (edges != 8 * (s + 2) + 1) begin
         errors++;
         $display("FAIL latency dut%0d: done after %0d edges, want %0d", d, edges, 8 * (s + 2) + 1);
      end
      ok = vals.size() >= 8 && vals.size() <= 9;
      base = ok ? vals.size() - 8 : 0;
      for (int k = 0; k < 8 && ok; k++) ok = vals[base+k] == 3'(k);
      for (int k = 1; k < 7 && ok; k++) ok = cnts[base+k] == s + 2;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL vector_order dut%0d: %0d distinct operand runs seen, want 0..7 in order each held %0d clocks",
                  d, vals.size(), s + 2);
      end
      ref_run(mode[d], d == 1 ? 2 : 4, e, f);
      checks++;
      if (c_err !== 4'(e) || c_ff !== 3'(f) || c_pass !== (e == 0) || c_vec !== 3'd7 || c_busy !== 1'b0) begin
         errors++;
         $display("FAIL results dut%0d mode%0d: err=%0d ff=%0d pass=%b vec=%0d busy=%b, want %0d %0d %b 7 0",
                  d, mode[d], c_err, c_ff, c_pass, c_vec, c_busy, e, f, e == 0);
      end
      if (hold) begin
         @(posedge clk);
         @(negedge clk);
         start[d] = 1'b0;
         checks++;
         if (c_done !== 1'b0 || c_busy !== 1'b1 || c_err !== 4'd0) begin
            errors++;
            $display("FAIL held_start_restart dut%0d: done=%b busy=%b err=%0d, want 0 1 0", d, c_done, c_busy, c_err);
         end
         edges = 1;
         while (c_done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
         end
         checks++;
         if (edges != 8 * (s + 2) + 1 || c_err !== 4'(e) || c_ff !== 3'(f)) begin
            errors++;
            $display("FAIL held_start_rerun dut%0d: edges=%0d err=%0d ff=%0d, want %0d %0d %0d",
                     d, edges, c_err, c_ff, 8 * (s + 2) + 1, e, f);
         end
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         cur = d;
         #1;
         checks++;
         if ({c_busy, c_done, c_pass, c_op, c_ff, c_vec} !== '0 || c_err !== 4'd0) begin
            errors++;
            $display("FAIL reset dut%0d: busy=%b done=%b pass=%b op=%0d ff=%0d vec=%0d err=%0d, want all 0",
                     d, c_busy, c_done, c_pass, c_op, c_ff, c_vec, c_err);
         end
      end
      nrst = 1'b1;
   endtask

   task automatic test_pass;
      mode[0] = 2'd0;
      run(0, 0, 1'b0);
   endtask

   task automatic test_cout_stuck;
      mode[0] = 2'd1;
      run(0, 0, 1'b0);
   endtask

   task automatic test_restart_done;
      mode[0] = 2'd0;
      run(0, 0, 1'b0);
   endtask

   task automatic test_hold_start;
      mode[0] = 2'd0;
      run(0, 0, 1'b1);
   endtask

   task automatic test_start_busy;
      mode[0] = 2'd1;
      run(0, int'($urandom_range(2, 22)), 1'b0);
      mode[0] = 2'd0;
      run(0, int'($urandom_range(2, 22)), 1'b0);
   endtask

   task automatic test_sum_inv;
      mode[0] = 2'd2;
      run(0, 0, 1'b0);
      mode[1] = 2'd2;
      run(1, 0, 1'b0);
   endtask

   task automatic test_random;
      for (int it = 0; it < 4; it++) begin
         for (int v = 0; v < 8; v++) flip[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         mode[0] = 2'd3;
         mode[1] = 2'd3;
         run(0, 0, 1'b0);
         run(1, 0, 1'b0);
      end
   endtask

   task automatic test_reset_mid;
      mode[0] = 2'd0;
      cur = 0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      checks++;
      if (c_vec !== 3'd4 || c_op !== 3'd4 || c_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_position: vec=%0d op=%0d busy=%b, want 4 4 1", c_vec, c_op, c_busy);
      end
      nrst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      checks++;
      if ({c_busy, c_done, c_pass, c_op, c_ff, c_vec} !== '0 || c_err !== 4'd0) begin
         errors++;
         $display("FAIL mid_run_reset: busy=%b done=%b pass=%b op=%0d ff=%0d vec=%0d err=%0d, want all 0",
                  c_busy, c_done, c_pass, c_op, c_ff, c_vec, c_err);
      end
      run(0, 0, 1'b0);
   endtask

   task automatic test_settle3;
      mode[2] = 2'd0;
      run(2, 0, 1'b0);
      for (int v = 0; v < 8; v++) flip[v] = 2'($urandom_range(0, 3));
      mode[2] = 2'd3;
      run(2, int'($urandom_range(2, 38)), 1'b0);
   endtask

   initial begin
      test_reset;
      test_pass;
      test_cout_stuck;
      test_restart_done;
      test_hold_start;
      test_start_busy;
      test_sum_inv;
      test_random;
      test_reset_mid;
      test_settle3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
